// File: rtl/alu_pkg.sv
// Shared types for the iterative add/sub unit: FSM state encoding,
// result flag bundle and a small overflow helper.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } flags_t;

    // Two's-complement overflow: operands agree in sign, result disagrees.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple slice with carry in and carry out.
module add_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/add_sub_iter.sv
// Iterative adder/subtractor: processes CHUNK bits per cycle over
// K = WIDTH/CHUNK cycles, with valid/ready handshakes on both sides.
// Optional saturation (port Sat) is enabled by defining ADD_SUB_ITER_SAT_EN.
module add_sub_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sign,
    input  logic             Sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] S,
    output logic             Z,
    output logic             V,
    output logic             N,
    output logic             out_valid,
    input  logic             out_ready
`ifdef ADD_SUB_ITER_SAT_EN
    ,
    input  logic             Sat
`endif
);

    localparam int K    = (CHUNK > 0) ? WIDTH / CHUNK : 1;
    localparam int IDXW = (K > 1) ? $clog2(K) : 1;

    // Reject geometries that cannot be split into whole chunks.
    generate
        if (CHUNK < 1) begin : g_bad_chunk
            $error("add_sub_iter: CHUNK must be at least 1");
        end else if ((WIDTH % CHUNK) != 0) begin : g_bad_ratio
            $error("add_sub_iter: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  a_reg, b_reg;        // b_reg holds B or ~B
    logic              sign_reg, sub_reg, carry_reg;
    logic [IDXW-1:0]   idx_reg;
    logic [WIDTH-1:0]  sum_reg, sum_next;   // partial sum under construction
    logic [WIDTH-1:0]  s_reg, res_final;
    flags_t            flags_reg, flags_final;
    logic [CHUNK-1:0]  a_chunk, b_chunk, chunk_s;
    logic              chunk_cout;
    logic              last_chunk;
`ifdef ADD_SUB_ITER_SAT_EN
    logic              sat_reg;
`endif

    assign last_chunk = (idx_reg == IDXW'(K - 1));
    assign a_chunk    = CHUNK'(a_reg >> (idx_reg * CHUNK));
    assign b_chunk    = CHUNK'(b_reg >> (idx_reg * CHUNK));

    add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_reg),
        .s    (chunk_s),
        .cout (chunk_cout)
    );

    // Merge the freshly computed chunk into the partial sum at the current index.
    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_merge
            assign sum_next[gi*CHUNK +: CHUNK] =
                (idx_reg == IDXW'(gi)) ? chunk_s : sum_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    // Final result and flags, valid when the last chunk is being added.
    always_comb begin
        res_final   = sum_next;
        flags_final = '0;
        if (sign_reg) begin
            flags_final.v = signed_ovf(a_reg[WIDTH-1], b_reg[WIDTH-1], sum_next[WIDTH-1]);
            flags_final.n = sum_next[WIDTH-1] ^ flags_final.v;
        end else begin
            // For subtraction the carry out is the inverted borrow.
            flags_final.v = sub_reg ? ~chunk_cout : chunk_cout;
            flags_final.n = 1'b0;
        end
`ifdef ADD_SUB_ITER_SAT_EN
        if (sat_reg && flags_final.v) begin
            if (sign_reg) begin
                res_final = flags_final.n ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                res_final = sub_reg ? '0 : '1;
            end
        end
`endif
        flags_final.z = (res_final == '0);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, chunk iteration and result/flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sign_reg  <= 1'b0;
            sub_reg   <= 1'b0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            sum_reg   <= '0;
            s_reg     <= '0;
            flags_reg <= '0;
`ifdef ADD_SUB_ITER_SAT_EN
            sat_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= A;
                        b_reg     <= Sub ? ~B : B;
                        sign_reg  <= Sign;
                        sub_reg   <= Sub;
                        carry_reg <= Sub;
                        idx_reg   <= '0;
                        sum_reg   <= '0;
`ifdef ADD_SUB_ITER_SAT_EN
                        sat_reg   <= Sat;
`endif
                    end
                end
                BUSY: begin
                    sum_reg   <= sum_next;
                    carry_reg <= chunk_cout;
                    if (last_chunk) begin
                        idx_reg   <= '0;
                        s_reg     <= res_final;
                        flags_reg <= flags_final;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign S = s_reg;
    assign Z = flags_reg.z;
    assign V = flags_reg.v;
    assign N = flags_reg.n;

endmodule

// File: tb/tb_add_sub_iter.sv
// Scoreboard bench for add_sub_iter (WIDTH=32, CHUNK=8).
// Saturation cases are exercised when ADD_SUB_ITER_SAT_EN is defined.
module tb_add_sub_iter;

    localparam int W  = 32;
    localparam int CH = 8;
    localparam int K  = W / CH;
`ifdef ADD_SUB_ITER_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] s;
        logic         z;
        logic         v;
        logic         n;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] a = '0, b = '0;
    logic         sign = 1'b0, sub = 1'b0, sat = 1'b0;
    logic         in_valid = 1'b0, out_ready = 1'b0;
    logic         in_ready, out_valid, z, v, n;
    logic [W-1:0] s;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   n_ops = 0;

    add_sub_iter #(.WIDTH(W), .CHUNK(CH)) dut (
        .clk       (clk),
        .reset     (reset),
        .A         (a),
        .B         (b),
        .Sign      (sign),
        .Sub       (sub),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (s),
        .Z         (z),
        .V         (v),
        .N         (n),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ADD_SUB_ITER_SAT_EN
        ,
        .Sat       (sat)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: exact arithmetic in W+2 bits, then range tests.
    function automatic exp_t model(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                   input logic sign_i, input logic sub_i, input logic sat_i);
        exp_t r;
        logic signed [W+1:0] sa, sbv, sx;
        logic [W+1:0] ux;
        r = '0;
        if (sign_i) begin
            sa  = {{2{a_i[W-1]}}, a_i};
            sbv = {{2{b_i[W-1]}}, b_i};
            sx  = sub_i ? (sa - sbv) : (sa + sbv);
            r.s = sx[W-1:0];
            r.v = (sx[W+1:W-1] != 3'b000) && (sx[W+1:W-1] != 3'b111);
            r.n = sx[W+1];
        end else begin
            ux  = sub_i ? ({2'b00, a_i} - {2'b00, b_i}) : ({2'b00, a_i} + {2'b00, b_i});
            r.s = ux[W-1:0];
            r.v = sub_i ? ux[W+1] : ux[W];
            r.n = 1'b0;
        end
        if (SAT_EN && sat_i && r.v) begin
            if (sign_i) r.s = r.n ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            else        r.s = sub_i ? '0 : '1;
        end
        r.z = (r.s == '0);
        return r;
    endfunction

    // One full transaction: accept, latency check, optional DONE stall, release.
    task automatic run_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                          input logic sign_i, input logic sub_i, input logic sat_i,
                          input int hold);
        int   wait_n;
        int   lat;
        exp_t e;
        logic [W-1:0] s_seen;
        @(negedge clk);
        wait_n = 0;
        while (!in_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check("in_ready_idle", W'(in_ready), W'(1'b1));
        a = a_i; b = b_i; sign = sign_i; sub = sub_i; sat = sat_i;
        in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back(model(a_i, b_i, sign_i, sub_i, sat_i));
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; sign = ~sign_i; sub = ~sub_i; sat = ~sat_i;
        lat = 0;
        while (!out_valid && lat < 4 * K + 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", W'(lat), W'(K));
        if (sb_q.size() == 0) begin
            check("sb_empty", W'(1'b1), W'(1'b0));
            e = '0;
        end else begin
            e = sb_q.pop_front();
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = $urandom;
            check("hold_in_ready", W'(in_ready), W'(1'b0));
            check("hold_out_valid", W'(out_valid), W'(1'b1));
            check("hold_s", s, e.s);
            check("hold_flags", W'({z, v, n}), W'({e.z, e.v, e.n}));
        end
        @(negedge clk);
        in_valid = 1'b0;
        s_seen = s;
        check("s", s, e.s);
        check("z", W'(z), W'(e.z));
        check("v", W'(v), W'(e.v));
        check("n", W'(n), W'(e.n));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_out_valid", W'(out_valid), W'(1'b0));
        check("release_in_ready", W'(in_ready), W'(1'b1));
        n_ops++;
        $display("op %0d: sign=%0d sub=%0d sat=%0d A=%h B=%h hold=%0d -> S=%h Z=%0d V=%0d N=%0d lat=%0d",
                 n_ops, sign_i, sub_i, sat_i, a_i, b_i, hold, s_seen, e.z, e.v, e.n, lat);
    endtask

    // Accept an operation, then reset it in its second BUSY cycle.
    task automatic reset_in_busy();
        int seen;
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h1111_1111; sign = 1'b0; sub = 1'b0; sat = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy_out_valid", W'(out_valid), W'(1'b0));
        check("rst_busy_in_ready", W'(in_ready), W'(1'b1));
        check("rst_busy_s", s, '0);
        check("rst_busy_flags", W'({z, v, n}), W'(3'b000));
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 3 * K + 5; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_busy_no_result", W'(seen), W'(0));
        n_ops++;
        $display("op %0d: reset during BUSY, out_valid pulses seen=%0d", n_ops, seen);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic rsg, rsu, rst_;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", W'(out_valid), W'(1'b0));
        check("reset_in_ready", W'(in_ready), W'(1'b1));
        check("reset_s", s, '0);
        check("reset_flags", W'({z, v, n}), W'(3'b000));
        @(negedge clk);
        reset = 1'b0;

        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 5);
        run_op(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 0);
        run_op(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 1'b0, 0);
        reset_in_busy();
        run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1);
        run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 0);
        run_op(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 1'b0, 0);
        if (SAT_EN) begin
            run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 0);
            run_op(32'h0000_0002, 32'h0000_0005, 1'b0, 1'b1, 1'b1, 0);
            run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 0);
            run_op(32'hFFFF_FFF0, 32'h0000_0020, 1'b0, 1'b0, 1'b1, 0);
        end
        for (int i = 0; i < 10; i++) begin
            ra = $urandom; rb = $urandom;
            rsg = 1'($urandom_range(0, 1));
            rsu = 1'($urandom_range(0, 1));
            rst_ = 1'($urandom_range(0, 1));
            run_op(ra, rb, rsg, rsu, rst_, int'($urandom_range(0, 2)));
        end
        check("sb_drained", W'(sb_q.size()), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
